// File: rtl/free_list_pkg.sv
// ============================================================================
// Module : free_list_pkg
// Brief  : Shared rename constants and types for the physical-register free list.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package free_list_pkg;

    localparam int PREG_WIDTH = 7;
    localparam int NUM_PREGS  = 128;
    localparam int NUM_AREGS  = 32;
    localparam int FL_DEPTH   = NUM_PREGS - NUM_AREGS;
    localparam int FL_PTR_W   = $clog2(FL_DEPTH);

    typedef logic [PREG_WIDTH-1:0] preg_t;
    typedef logic [FL_PTR_W-1:0]   fl_ptr_t;

    // Distance from base to idx walking forward around a ring of the given depth.
    function automatic int fl_ring_offset(input int idx, input int base, input int depth);
        return (idx >= base) ? (idx - base) : (idx + depth - base);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fl_ptr_inc.sv
// ============================================================================
// Module : fl_ptr_inc
// Brief  : Conditional pointer increment with explicit wrap at DEPTH-1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fl_ptr_inc #(
    parameter int DEPTH = 96,
    parameter int PTR_W = 7
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    // DEPTH need not be a power of two, so wrap is a compare, not a mask.
    always_comb begin
        ptr_o = ptr_i;
        if (inc_i) begin
            ptr_o = (ptr_i == PTR_W'(DEPTH - 1)) ? '0 : ptr_i + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/free_list.sv
// ============================================================================
// Module : free_list
// Brief  : Circular FIFO of free physical registers with one head checkpoint.
//          Optional double-free detection: FREE_LIST_DBL_FREE_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module free_list #(
    parameter int PREG_WIDTH = free_list_pkg::PREG_WIDTH,
    parameter int NUM_PREGS  = free_list_pkg::NUM_PREGS,
    parameter int NUM_AREGS  = free_list_pkg::NUM_AREGS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [PREG_WIDTH-1:0] alloc_preg,
    input  logic                  free_valid,
    input  logic [PREG_WIDTH-1:0] free_preg,
    input  logic                  checkpoint,
    input  logic                  restore,
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    output logic                  double_free_err,
`endif
    output logic [PREG_WIDTH-1:0] free_count
);

    import free_list_pkg::*;

    localparam int DEPTH = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W = $clog2(DEPTH);

    logic [PREG_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      head_q, head_d, head_inc, tail_q, tail_d, snap_q;
    logic [PREG_WIDTH-1:0] count_q, count_d, count_after_alloc;
    logic [PREG_WIDTH-1:0] asc_q, asc_d;
    logic                  alloc_fire, free_fire, free_ok;

    assign alloc_valid       = (count_q != '0);
    assign alloc_preg        = mem_q[head_q];
    assign free_count        = count_q;
    assign alloc_fire        = alloc_req && alloc_valid && !restore;
    assign count_after_alloc = count_q - PREG_WIDTH'(alloc_fire);
    assign free_fire         = free_valid && (free_preg != '0)
                               && (count_after_alloc < PREG_WIDTH'(DEPTH)) && free_ok;

    fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head_inc (
        .ptr_i (head_q),
        .inc_i (alloc_fire),
        .ptr_o (head_inc)
    );

    fl_ptr_inc #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail_inc (
        .ptr_i (tail_q),
        .inc_i (free_fire),
        .ptr_o (tail_d)
    );

    always_comb begin
        head_d  = restore ? snap_q : head_inc;
        count_d = count_after_alloc + PREG_WIDTH'(free_fire);
        asc_d   = asc_q;
        if (restore) begin
            count_d = count_q + asc_q + PREG_WIDTH'(free_fire);
            asc_d   = '0;
        end else if (checkpoint) begin
            asc_d   = '0;
        end else if (alloc_fire && (asc_q != PREG_WIDTH'(DEPTH))) begin
            asc_d   = asc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_WIDTH'(NUM_AREGS + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            snap_q  <= '0;
            count_q <= PREG_WIDTH'(DEPTH);
            asc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            asc_q   <= asc_d;
            // Snapshot is post-rename so it lines up with the map-table shadow.
            if (checkpoint && !restore) begin
                snap_q <= head_d;
            end
            if (free_fire) begin
                mem_q[tail_q] <= free_preg;
            end
        end
    end

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    logic [NUM_PREGS-1:0] in_list_q, in_list_d;
    logic                 dbl_err_q;

    assign free_ok         = !in_list_q[free_preg];
    assign double_free_err = dbl_err_q;

    // Squashed range is the asc_q slots starting at the snapshot head.
    always_comb begin
        in_list_d = in_list_q;
        if (alloc_fire) begin
            in_list_d[alloc_preg] = 1'b0;
        end
        if (restore) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fl_ring_offset(i, int'(snap_q), DEPTH) < int'(asc_q)) begin
                    in_list_d[mem_q[i]] = 1'b1;
                end
            end
        end
        if (free_fire) begin
            in_list_d[free_preg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_list_q <= {{DEPTH{1'b1}}, {NUM_AREGS{1'b0}}};
            dbl_err_q <= 1'b0;
        end else begin
            in_list_q <= in_list_d;
            dbl_err_q <= free_valid && (free_preg != '0) && in_list_q[free_preg];
        end
    end
`else
    assign free_ok = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
// ============================================================================
// Module : tb_free_list
// Brief  : Directed self-checking bench for free_list.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_free_list;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    logic [6:0] alloc_preg;
    logic       free_valid = 1'b0;
    logic [6:0] free_preg = '0;
    logic       checkpoint = 1'b0;
    logic       restore = 1'b0;
    logic [6:0] free_count;
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    logic       double_free_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    free_list dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_req   (alloc_req),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .free_valid  (free_valid),
        .free_preg   (free_preg),
        .checkpoint  (checkpoint),
        .restore     (restore),
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
        .double_free_err (double_free_err),
`endif
        .free_count  (free_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req  = 1'b0;
        free_valid = 1'b0;
        free_preg  = '0;
        checkpoint = 1'b0;
        restore    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (alloc_valid !== 1'b1) begin n_err++; $display("FAIL reset_valid: got %0b want 1", alloc_valid); end
        n_cmp++; if (alloc_preg !== 7'd32) begin n_err++; $display("FAIL reset_preg: got %0d want 32", alloc_preg); end
        n_cmp++; if (free_count !== 7'd96) begin n_err++; $display("FAIL reset_count: got %0d want 96", free_count); end
        // Free on a full list is dropped.
        free_valid = 1'b1; free_preg = 7'd7;
        tick();
        idle();
        n_cmp++; if (free_count !== 7'd96) begin n_err++; $display("FAIL overflow_count: got %0d want 96", free_count); end
        n_cmp++; if (alloc_preg !== 7'd32) begin n_err++; $display("FAIL overflow_preg: got %0d want 32", alloc_preg); end
    endtask

    task automatic test_alloc();
        do_reset();
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (alloc_preg !== 7'(32 + i)) begin n_err++; $display("FAIL alloc_seq[%0d]: got %0d want %0d", i, alloc_preg, 32 + i); end
            tick();
        end
        idle();
        n_cmp++; if (free_count !== 7'd93) begin n_err++; $display("FAIL alloc_count: got %0d want 93", free_count); end
        n_cmp++; if (alloc_preg !== 7'd35) begin n_err++; $display("FAIL alloc_next: got %0d want 35", alloc_preg); end
        // Mid-operation reset discards everything.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (free_count !== 7'd96) begin n_err++; $display("FAIL midreset_count: got %0d want 96", free_count); end
        n_cmp++; if (alloc_preg !== 7'd32) begin n_err++; $display("FAIL midreset_preg: got %0d want 32", alloc_preg); end
    endtask

    task automatic test_empty();
        do_reset();
        alloc_req = 1'b1;
        repeat (96) tick();
        n_cmp++; if (alloc_valid !== 1'b0) begin n_err++; $display("FAIL empty_valid: got %0b want 0", alloc_valid); end
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL empty_count: got %0d want 0", free_count); end
        tick();
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL empty_ignore: got %0d want 0", free_count); end
        free_valid = 1'b1; free_preg = 7'd0;
        tick();
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL free_p0: got %0d want 0", free_count); end
        // Free while empty with alloc_req held: the alloc must not bypass.
        free_preg = 7'd5;
        tick();
        free_valid = 1'b0;
        n_cmp++; if (alloc_valid !== 1'b1) begin n_err++; $display("FAIL refill_valid: got %0b want 1", alloc_valid); end
        n_cmp++; if (alloc_preg !== 7'd5) begin n_err++; $display("FAIL refill_preg: got %0d want 5", alloc_preg); end
        n_cmp++; if (free_count !== 7'd1) begin n_err++; $display("FAIL no_bypass_count: got %0d want 1", free_count); end
        tick();
        idle();
        n_cmp++; if (free_count !== 7'd0) begin n_err++; $display("FAIL realloc_count: got %0d want 0", free_count); end
    endtask

    task automatic test_checkpoint();
        do_reset();
        alloc_req = 1'b1; checkpoint = 1'b1;
        tick();
        checkpoint = 1'b0;
        tick();
        tick();
        n_cmp++; if (free_count !== 7'd93) begin n_err++; $display("FAIL ckpt_pre_count: got %0d want 93", free_count); end
        restore = 1'b1;
        tick();
        idle();
        n_cmp++; if (alloc_preg !== 7'd33) begin n_err++; $display("FAIL restore_preg: got %0d want 33", alloc_preg); end
        n_cmp++; if (free_count !== 7'd95) begin n_err++; $display("FAIL restore_count: got %0d want 95", free_count); end
    endtask

    task automatic test_restore_free();
        do_reset();
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0; checkpoint = 1'b1;
        tick();
        checkpoint = 1'b0; alloc_req = 1'b1;
        tick();
        tick();
        n_cmp++; if (free_count !== 7'd93) begin n_err++; $display("FAIL rf_pre_count: got %0d want 93", free_count); end
        restore = 1'b1; free_valid = 1'b1; free_preg = 7'd7;
        tick();
        idle();
        n_cmp++; if (free_count !== 7'd96) begin n_err++; $display("FAIL rf_count: got %0d want 96", free_count); end
        n_cmp++; if (alloc_preg !== 7'd33) begin n_err++; $display("FAIL rf_head: got %0d want 33", alloc_preg); end
        alloc_req = 1'b1;
        for (int i = 0; i < 95; i++) begin
            n_cmp++; if (alloc_preg !== 7'(33 + i)) begin n_err++; $display("FAIL rf_drain[%0d]: got %0d want %0d", i, alloc_preg, 33 + i); end
            tick();
        end
        idle();
        n_cmp++; if (alloc_preg !== 7'd7) begin n_err++; $display("FAIL rf_tail_p7: got %0d want 7", alloc_preg); end
    endtask

    task automatic test_wrap();
        logic [6:0] held[$];
        logic [6:0] expq[$];
        logic [6:0] e;
        logic [6:0] f;
        do_reset();
        for (int i = 32; i < 128; i++) expq.push_back(7'(i));
        alloc_req = 1'b1;
        repeat (10) begin
            e = expq.pop_front();
            held.push_back(e);
            tick();
        end
        n_cmp++; if (free_count !== 7'd86) begin n_err++; $display("FAIL wrap_pre_count: got %0d want 86", free_count); end
        for (int k = 0; k < 200; k++) begin
            e = expq.pop_front();
            f = held.pop_front();
            held.push_back(e);
            expq.push_back(f);
            free_valid = 1'b1; free_preg = f;
            n_cmp++; if (alloc_preg !== e) begin n_err++; $display("FAIL wrap_preg[%0d]: got %0d want %0d", k, alloc_preg, e); end
            tick();
            n_cmp++; if (free_count !== 7'd86) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want 86", k, free_count); end
        end
        idle();
        n_cmp++; if (alloc_preg !== expq[0]) begin n_err++; $display("FAIL wrap_final: got %0d want %0d", alloc_preg, expq[0]); end
    endtask

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    task automatic test_dbl_free();
        do_reset();
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
        free_valid = 1'b1; free_preg = 7'd40;
        tick();
        free_valid = 1'b0;
        n_cmp++; if (double_free_err !== 1'b1) begin n_err++; $display("FAIL dbl_err_set: got %0b want 1", double_free_err); end
        n_cmp++; if (free_count !== 7'd95) begin n_err++; $display("FAIL dbl_count: got %0d want 95", free_count); end
        tick();
        n_cmp++; if (double_free_err !== 1'b0) begin n_err++; $display("FAIL dbl_err_pulse: got %0b want 0", double_free_err); end
        free_valid = 1'b1; free_preg = 7'd32;
        tick();
        idle();
        n_cmp++; if (double_free_err !== 1'b0) begin n_err++; $display("FAIL dbl_legal_err: got %0b want 0", double_free_err); end
        n_cmp++; if (free_count !== 7'd96) begin n_err++; $display("FAIL dbl_legal_count: got %0d want 96", free_count); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alloc();
        test_empty();
        test_checkpoint();
        test_restore_free();
        test_wrap();
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
        test_dbl_free();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
